mix_columns_seq: RTL and testbench

- Sequencer that time-shares one 32-bit mix_columns unit across the four columns of a 128-bit AES state, one column per cycle.
- Sits between the SubBytes/ShiftRows stage and AddRoundKey in the iterative round datapath.
- Uses valid/ready handshakes on both sides.
- A bypass request passes the state through untouched, for the final AES round.

---
 rtl/mix_columns_seq.sv | 109 ++++++++++
 tb/tb_mix_columns_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Time-shares one external 32-bit mix_columns unit across the four columns of
// a 128-bit AES state, one column per cycle, with valid/ready on both sides.
module mix_columns_seq #(
  parameter int unsigned STATE_WIDTH = 128,
  parameter int unsigned COL_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_bypass,
  input  logic [STATE_WIDTH-1:0] state_in,
  output logic [COL_WIDTH-1:0]   mc_col_o,
  input  logic [COL_WIDTH-1:0]   mc_col_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STATE_WIDTH-1:0] state_out,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             col_cnt_q, col_cnt_d;
  logic [STATE_WIDTH-1:0] buf_q, buf_d;
  logic                   bypass_q, bypass_d;
  logic [COL_WIDTH-1:0]   cur_col;

  always_comb begin
    cur_col = '0;
    case (col_cnt_q)
      2'd0:    cur_col = buf_q[127:96];
      2'd1:    cur_col = buf_q[95:64];
      2'd2:    cur_col = buf_q[63:32];
      default: cur_col = buf_q[31:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    buf_d     = buf_q;
    bypass_d  = bypass_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mc_col_o  = '0;
    busy      = (state_q != IDLE);
    state_out = buf_q;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          buf_d     = state_in;
          bypass_d  = in_bypass;
          col_cnt_d = 2'd0;
          state_d   = in_bypass ? DONE : BUSY;
        end
      end
      BUSY: begin
        mc_col_o = cur_col;
        // A bypassed state never needs the shared unit; skip straight out.
        if (bypass_q) begin
          state_d = DONE;
        end else begin
          case (col_cnt_q)
            2'd0:    buf_d[127:96] = mc_col_i;
            2'd1:    buf_d[95:64]  = mc_col_i;
            2'd2:    buf_d[63:32]  = mc_col_i;
            default: buf_d[31:0]   = mc_col_i;
          endcase
          col_cnt_d = col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d   = IDLE;
      col_cnt_d = 2'd0;
      bypass_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      buf_q     <= '0;
      bypass_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      buf_q     <= buf_d;
      bypass_q  <= bypass_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq with a behavioural
// mix_columns unit closing the combinational loop through mc_col_o/mc_col_i.
module tb_mix_columns_seq;

  logic         CLK;
  logic         RST;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_bypass;
  logic [127:0] state_in;
  logic [31:0]  mc_col_o;
  logic [31:0]  mc_col_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  int unsigned n_checks;
  int unsigned n_fail;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BP_IN    = 128'hc6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] BP_OUT   = 128'hc6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6;

  mix_columns_seq #(.STATE_WIDTH(128), .COL_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass),
    .state_in(state_in), .mc_col_o(mc_col_o), .mc_col_i(mc_col_i),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out),
    .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  assign mc_col_i = mixcol(mc_col_o);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Accept a state from IDLE: drive inputs, pass the accept edge, drop in_valid.
  task automatic offer(input logic [127:0] s, input logic byp);
    state_in  = s;
    in_bypass = byp;
    in_valid  = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL offer_ready: in_ready=%b expected 1", in_ready);
    end
    step();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bypass = 1'b0;
    state_in = '0; out_ready = 1'b1;
    #12;
    RST = 1'b1;
    step(); step();
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    n_checks++;
    if (mc_col_o !== 32'h0 || state_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: mc_col_o=%h state_out=%h expected 0", mc_col_o, state_out);
    end
  endtask

  task automatic test_fips();
    logic [127:0] src;
    logic [31:0]  exp_col;
    src = FIPS_IN;
    out_ready = 1'b1;
    offer(FIPS_IN, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_col = src[127 - 32*k -: 32];
      n_checks++;
      if (mc_col_o !== exp_col || out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL fips_col%0d: mc_col_o=%h ov=%b busy=%b ir=%b expected %h 0 1 0",
                 k, mc_col_o, out_valid, busy, in_ready, exp_col);
      end
      step();
    end
    chk1("fips_out_valid", out_valid, 1'b1);
    n_checks++;
    if (state_out !== FIPS_OUT) begin
      n_fail++;
      $display("FAIL fips_state_out: got %h expected %h", state_out, FIPS_OUT);
    end
    n_checks++;
    if (mc_col_o !== 32'h0) begin
      n_fail++;
      $display("FAIL fips_done_quiet: mc_col_o=%h expected 0", mc_col_o);
    end
    step();
    chk1("fips_back_idle", busy, 1'b0);
  endtask

  task automatic test_bypass();
    out_ready = 1'b1;
    offer(BYP_IN, 1'b1);
    chk1("bypass_out_valid", out_valid, 1'b1);
    n_checks++;
    if (state_out !== BYP_IN || mc_col_o !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_data: state_out=%h mc_col_o=%h expected %h 0", state_out, mc_col_o, BYP_IN);
    end
    step();
    chk1("bypass_idle", in_ready, 1'b1);
    chk1("bypass_ov_drop", out_valid, 1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(BP_IN, 1'b0);
    step(); step(); step(); step();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || state_out !== BP_OUT || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ov=%b ir=%b state_out=%h expected 1 0 %h",
                 k, out_valid, in_ready, state_out, BP_OUT);
      end
      step();
    end
    out_ready = 1'b1;
    chk1("bp_still_valid", out_valid, 1'b1);
    step();
    chk1("bp_idle_busy", busy, 1'b0);
    chk1("bp_idle_ready", in_ready, 1'b1);
  endtask

  task automatic test_back_to_back();
    int accept_cyc[2];
    logic [127:0] results[$];
    int n_acc;
    n_acc = 0;
    out_ready = 1'b1;
    state_in  = FIPS_IN;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (out_valid === 1'b1) results.push_back(state_out);
      if (in_valid && in_ready === 1'b1 && n_acc < 2) begin
        accept_cyc[n_acc] = cyc;
        n_acc++;
      end
      step();
      if (n_acc == 1) state_in = BP_IN;
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_acc != 2 || accept_cyc[1] - accept_cyc[0] != 6) begin
      n_fail++;
      $display("FAIL b2b_spacing: accepts=%0d gap=%0d expected 2 accepts gap 6",
               n_acc, (n_acc == 2) ? accept_cyc[1] - accept_cyc[0] : -1);
    end
    n_checks++;
    if (results.size() != 2 || results[0] !== FIPS_OUT || results[1] !== BP_OUT) begin
      n_fail++;
      $display("FAIL b2b_results: count=%0d expected 2 results %h %h",
               results.size(), FIPS_OUT, BP_OUT);
    end
  endtask

  task automatic test_flush();
    logic seen_valid;
    out_ready = 1'b1;
    offer(FIPS_IN, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("flush_idle_busy", busy, 1'b0);
    chk1("flush_idle_ready", in_ready, 1'b1);
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid !== 1'b0) seen_valid = 1'b1;
      step();
    end
    chk1("flush_no_out_valid", seen_valid, 1'b0);
    // flush coincident with in_valid in IDLE must not accept
    state_in = BP_IN; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk1("flush_blocks_accept", busy, 1'b0);
    offer(BP_IN, 1'b0);
    step(); step(); step(); step();
    chk1("flush_recover_valid", out_valid, 1'b1);
    n_checks++;
    if (state_out !== BP_OUT) begin
      n_fail++;
      $display("FAIL flush_recover_data: got %h expected %h", state_out, BP_OUT);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    offer(FIPS_IN, 1'b0);
    step(); step();
    chk1("ares_pre_busy", busy, 1'b1);
    #1;
    RST = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        mc_col_o !== 32'h0 || state_out !== 128'h0) begin
      n_fail++;
      $display("FAIL ares_immediate: busy=%b ir=%b ov=%b mc=%h so=%h expected 0 1 0 0 0",
               busy, in_ready, out_valid, mc_col_o, state_out);
    end
    step();
    RST = 1'b1;
    step();
    offer(BYP_IN, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || state_out !== BYP_IN) begin
      n_fail++;
      $display("FAIL ares_recover: ov=%b so=%h expected 1 %h", out_valid, state_out, BYP_IN);
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fips();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
